// File: rtl/dac_serial_bridge.sv
// DUC-to-DAC serial bridge: rounds I/Q samples to offset-binary DAC codes,
// queues them, and shifts each pair out MSB first on D1/D2 framed by nSYNC.
module dac_serial_bridge #(
   parameter int CLK_DIV    = 2,
   parameter int FIFO_DEPTH = 8,
   parameter int IN_W       = 16,
   parameter int DAC_W      = 12
) (
   input  logic                        clk_in,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [IN_W-1:0]             in_re,
   input  logic [IN_W-1:0]             in_im,
   output logic                        D1,
   output logic                        D2,
   output logic                        CLK_OUT,
   output logic                        nSYNC,
   output logic                        frame_done,
   output logic                        busy,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int FW = 16;
   localparam int BW = $clog2(FW);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PW = FW - DAC_W;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_t;

   // s holds the DAC_W code bits plus the first discarded bit (round bit)
   function automatic logic [DAC_W-1:0] to_code(input logic [DAC_W:0] s);
      logic [DAC_W-1:0] top;
      logic [DAC_W-1:0] c;
      top = s[DAC_W:1];
      if (top == {1'b0, {(DAC_W-1){1'b1}}} && s[0])
         c = top;
      else
         c = top + DAC_W'(s[0]);
      return {~c[DAC_W-1], c[DAC_W-2:0]};
   endfunction

   logic [DAC_W-1:0]   code_re;
   logic [DAC_W-1:0]   code_im;
   logic               unused_lsb;

   assign code_re    = to_code(in_re[IN_W-1 -: DAC_W+1]);
   assign code_im    = to_code(in_im[IN_W-1 -: DAC_W+1]);
   assign unused_lsb = ^{in_re[IN_W-DAC_W-2:0], in_im[IN_W-DAC_W-2:0]};

   logic [2*DAC_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]      level_q, level_d;
   logic               overflow_q, overflow_d;
   logic [2*DAC_W-1:0] rd_data;
   logic               full;
   logic               push;
   logic               pop;

   state_t             state_q, state_d;
   logic [DW-1:0]      div_cnt_q, div_cnt_d;
   logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
   logic               clk_out_q, clk_out_d;
   logic               nsync_q, nsync_d;
   logic               frame_done_q, frame_done_d;
   logic               gap_half_q, gap_half_d;
   logic [FW-1:0]      sr1_q, sr1_d;
   logic [FW-1:0]      sr2_q, sr2_d;
   logic               tick;

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = (level_q == LW'(FIFO_DEPTH));
   assign push    = in_valid && (!full || pop);
   assign tick    = (div_cnt_q == DW'(CLK_DIV - 1));

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (push)
         wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)
         rd_ptr_d = rd_ptr_q + AW'(1);
      if (in_valid && !push)
         overflow_d = 1'b1;
      level_d = level_q + LW'(push) - LW'(pop);
   end

   always_comb begin
      state_d      = state_q;
      div_cnt_d    = div_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      clk_out_d    = clk_out_q;
      nsync_d      = nsync_q;
      sr1_d        = sr1_q;
      sr2_d        = sr2_q;
      gap_half_d   = gap_half_q;
      frame_done_d = 1'b0;
      pop          = 1'b0;
      unique case (state_q)
         IDLE: begin
            clk_out_d = 1'b1;
            nsync_d   = 1'b1;
            if (level_q != '0) begin
               pop       = 1'b1;
               sr1_d     = {{PW{1'b0}}, rd_data[2*DAC_W-1:DAC_W]};
               sr2_d     = {{PW{1'b0}}, rd_data[DAC_W-1:0]};
               nsync_d   = 1'b0;
               bit_cnt_d = '0;
               div_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
            if (tick) begin
               if (clk_out_q) begin
                  clk_out_d = 1'b0;
               end else begin
                  clk_out_d = 1'b1;
                  if (bit_cnt_q == BW'(FW - 1)) begin
                     nsync_d      = 1'b1;
                     sr1_d        = '0;
                     sr2_d        = '0;
                     frame_done_d = 1'b1;
                     div_cnt_d    = '0;
                     gap_half_d   = 1'b0;
                     state_d      = GAP;
                  end else begin
                     // data moves only on the rising edge
                     bit_cnt_d = bit_cnt_q + BW'(1);
                     sr1_d     = sr1_q << 1;
                     sr2_d     = sr2_q << 1;
                  end
               end
            end
         end
         GAP: begin
            div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
            if (tick) begin
               if (gap_half_q)
                  state_d = IDLE;
               else
                  gap_half_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (push)
         mem_q[wr_ptr_q] <= {code_re, code_im};
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         overflow_q   <= 1'b0;
         state_q      <= IDLE;
         div_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         clk_out_q    <= 1'b1;
         nsync_q      <= 1'b1;
         frame_done_q <= 1'b0;
         gap_half_q   <= 1'b0;
         sr1_q        <= '0;
         sr2_q        <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         overflow_q   <= overflow_d;
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         clk_out_q    <= clk_out_d;
         nsync_q      <= nsync_d;
         frame_done_q <= frame_done_d;
         gap_half_q   <= gap_half_d;
         sr1_q        <= sr1_d;
         sr2_q        <= sr2_d;
      end
   end

   assign D1         = sr1_q[FW-1];
   assign D2         = sr2_q[FW-1];
   assign CLK_OUT    = clk_out_q;
   assign nSYNC      = nsync_q;
   assign frame_done = frame_done_q;
   assign busy       = (state_q != IDLE);
   assign overflow   = overflow_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_dac_serial_bridge.sv
// Bench for dac_serial_bridge: two instances (CLK_DIV=2 and CLK_DIV=1)
// with a frame monitor checking every emitted frame against a scoreboard.
module tb_dac_serial_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  vld = '0;
   logic [15:0] re0 = '0, im0 = '0, re1 = '0, im1 = '0;
   logic [1:0]  d1, d2, clk_o, nsync, fdone, busy, ovf;
   logic [3:0]  lvl0, lvl1;

   typedef struct packed {
      logic [15:0] w1;
      logic [15:0] w2;
   } exp_t;

   exp_t        sbq0[$];
   exp_t        sbq1[$];
   int          starts0[$];
   int          starts1[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          low[2];
   int          fall[2];
   int          nstart[2] = '{0, 0};
   int          ndone[2] = '{0, 0};
   logic [15:0] w1[2];
   logic [15:0] w2[2];
   logic        pclk[2];
   logic        pns[2];

   always #5 clk = ~clk;

   dac_serial_bridge #(.CLK_DIV(2), .FIFO_DEPTH(8)) u_dut0 (
      .clk_in(clk), .rst(rst), .in_valid(vld[0]),
      .in_re(re0), .in_im(im0),
      .D1(d1[0]), .D2(d2[0]), .CLK_OUT(clk_o[0]), .nSYNC(nsync[0]),
      .frame_done(fdone[0]), .busy(busy[0]), .overflow(ovf[0]),
      .fifo_level(lvl0)
   );

   dac_serial_bridge #(.CLK_DIV(1), .FIFO_DEPTH(8)) u_dut1 (
      .clk_in(clk), .rst(rst), .in_valid(vld[1]),
      .in_re(re1), .in_im(im1),
      .D1(d1[1]), .D2(d2[1]), .CLK_OUT(clk_o[1]), .nSYNC(nsync[1]),
      .frame_done(fdone[1]), .busy(busy[1]), .overflow(ovf[1]),
      .fifo_level(lvl1)
   );

   // Reference rounding: nearest integer of x/16, halves up, clamped.
   function automatic logic [15:0] model(input logic [15:0] x);
      int v;
      v = int'($signed(x));
      v = (v + 8) >>> 4;
      if (v > 2047) v = 2047;
      if (v < -2048) v = -2048;
      return 16'(v + 2048);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      logic have;
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            low[k]  = 0;
            fall[k] = 0;
            pclk[k] = 1'b1;
            pns[k]  = 1'b1;
         end else begin
            if (fdone[k]) ndone[k]++;
            if (!nsync[k]) begin
               if (pns[k]) begin
                  low[k]  = 0;
                  fall[k] = 0;
                  w1[k]   = '0;
                  w2[k]   = '0;
                  nstart[k]++;
                  if (k == 0) starts0.push_back(cyc);
                  else starts1.push_back(cyc);
               end
               low[k]++;
               if (pclk[k] && !clk_o[k]) begin
                  fall[k]++;
                  w1[k] = {w1[k][14:0], d1[k]};
                  w2[k] = {w2[k][14:0], d2[k]};
               end
            end else if (!pns[k]) begin
               have = (k == 0) ? (sbq0.size() > 0) : (sbq1.size() > 0);
               checks++;
               if (!have) begin
                  errors++;
                  $display("FAIL frame_unexpected dut%0d got %h/%h want none",
                           k, w1[k], w2[k]);
               end else begin
                  e = (k == 0) ? sbq0.pop_front() : sbq1.pop_front();
                  checks++;
                  if ({w1[k], w2[k]} !== {e.w1, e.w2}) begin
                     errors++;
                     $display("FAIL frame_data dut%0d got %h/%h want %h/%h",
                              k, w1[k], w2[k], e.w1, e.w2);
                  end
                  checks++;
                  if (low[k] !== 32 * ((k == 0) ? 2 : 1)) begin
                     errors++;
                     $display("FAIL nsync_low dut%0d got %0d want %0d",
                              k, low[k], 32 * ((k == 0) ? 2 : 1));
                  end
                  checks++;
                  if (fall[k] !== 16) begin
                     errors++;
                     $display("FAIL fall_edges dut%0d got %0d want 16",
                              k, fall[k]);
                  end
                  checks++;
                  if (fdone[k] !== 1'b1) begin
                     errors++;
                     $display("FAIL frame_done_align dut%0d got %b want 1",
                              k, fdone[k]);
                  end
               end
            end
            pclk[k] = clk_o[k];
            pns[k]  = nsync[k];
         end
      end
   end

   task automatic drive(input int k, input logic [15:0] re,
                        input logic [15:0] im, input bit acc);
      exp_t e;
      @(posedge clk);
      #1;
      e.w1 = model(re);
      e.w2 = model(im);
      if (k == 0) begin
         vld[0] = 1'b1;
         re0 = re;
         im0 = im;
         if (acc) sbq0.push_back(e);
      end else begin
         vld[1] = 1'b1;
         re1 = re;
         im1 = im;
         if (acc) sbq1.push_back(e);
      end
   endtask

   task automatic idle_in();
      @(posedge clk);
      #1;
      vld = '0;
   endtask

   task automatic wait_drain(input int k, input int bound);
      bit done = 1'b0;
      for (int i = 0; i < bound && !done; i++) begin
         @(negedge clk);
         if (k == 0) done = sbq0.size() == 0 && !busy[0] && lvl0 == 0;
         else done = sbq1.size() == 0 && !busy[1] && lvl1 == 0;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain_timeout dut%0d got pending want drained", k);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({nsync[k], clk_o[k], d1[k], d2[k]} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_pins dut%0d got %b want 1100",
                     k, {nsync[k], clk_o[k], d1[k], d2[k]});
         end
         checks++;
         if ({fdone[k], busy[k], ovf[k]} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags dut%0d got %b want 000",
                     k, {fdone[k], busy[k], ovf[k]});
         end
      end
      checks++;
      if (lvl0 !== 4'd0 || lvl1 !== 4'd0) begin
         errors++;
         $display("FAIL reset_level got %0d/%0d want 0/0", lvl0, lvl1);
      end
      #1 rst = 1'b0;
   endtask

   task automatic test_single();
      int base;
      base = ndone[0];
      drive(0, 16'h0000, 16'h1238, 1'b1);
      idle_in();
      @(negedge clk);
      checks++;
      if (nsync[0] !== 1'b1 || lvl0 !== 4'd1) begin
         errors++;
         $display("FAIL latency_push got nsync=%b lvl=%0d want 1/1",
                  nsync[0], lvl0);
      end
      @(negedge clk);
      checks++;
      if (nsync[0] !== 1'b0 || lvl0 !== 4'd0 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL latency_pop got nsync=%b lvl=%0d busy=%b want 0/0/1",
                  nsync[0], lvl0, busy[0]);
      end
      wait_drain(0, 400);
      checks++;
      if (ndone[0] - base !== 1) begin
         errors++;
         $display("FAIL done_pulses got %0d want 1", ndone[0] - base);
      end
   endtask

   task automatic test_saturation();
      drive(0, 16'h7FFF, 16'h8000, 1'b1);
      drive(0, 16'h7FF7, 16'hFFF8, 1'b1);
      drive(0, 16'hFFFF, 16'h0008, 1'b1);
      idle_in();
      wait_drain(0, 600);
   endtask

   task automatic test_overflow();
      starts0.delete();
      for (int i = 0; i < 10; i++)
         drive(0, 16'($urandom), 16'($urandom), i < 9);
      checks++;
      if (lvl0 !== 4'd8 || ovf[0] !== 1'b0) begin
         errors++;
         $display("FAIL pre_overflow got lvl=%0d ovf=%b want 8/0",
                  lvl0, ovf[0]);
      end
      idle_in();
      checks++;
      if (lvl0 !== 4'd8 || ovf[0] !== 1'b1) begin
         errors++;
         $display("FAIL overflow got lvl=%0d ovf=%b want 8/1", lvl0, ovf[0]);
      end
      wait_drain(0, 1500);
      checks++;
      if (starts0.size() !== 9) begin
         errors++;
         $display("FAIL frame_count got %0d want 9", starts0.size());
      end
      for (int i = 1; i < starts0.size(); i++) begin
         checks++;
         if (starts0[i] - starts0[i-1] !== 69) begin
            errors++;
            $display("FAIL frame_period got %0d want 69",
                     starts0[i] - starts0[i-1]);
         end
      end
      checks++;
      if (ovf[0] !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky got %b want 1", ovf[0]);
      end
   endtask

   task automatic test_reset_mid_frame();
      int  base;
      int  ns;
      bit  hit = 1'b0;
      base = ndone[0];
      for (int i = 0; i < 5; i++)
         drive(0, 16'($urandom), 16'($urandom), 1'b1);
      idle_in();
      for (int i = 0; i < 400 && !hit; i++) begin
         @(negedge clk);
         hit = ndone[0] == base + 1 && fall[0] == 8 && !nsync[0];
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL mid_frame_reach got timeout want frame2 bit7");
      end
      checks++;
      if (lvl0 !== 4'd3) begin
         errors++;
         $display("FAIL mid_frame_level got %0d want 3", lvl0);
      end
      #1 rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({nsync[0], clk_o[0], d1[0], d2[0], busy[0]} !== 5'b11000) begin
         errors++;
         $display("FAIL mid_reset_pins got %b want 11000",
                  {nsync[0], clk_o[0], d1[0], d2[0], busy[0]});
      end
      checks++;
      if (lvl0 !== 4'd0 || ovf[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_fifo got lvl=%0d ovf=%b want 0/0",
                  lvl0, ovf[0]);
      end
      #1 rst = 1'b0;
      sbq0.delete();
      ns = nstart[0];
      repeat (300) @(negedge clk);
      checks++;
      if (nstart[0] !== ns || busy[0] !== 1'b0 || lvl0 !== 4'd0) begin
         errors++;
         $display("FAIL post_reset_idle got starts=%0d busy=%b want %0d/0",
                  nstart[0], busy[0], ns);
      end
   endtask

   task automatic test_push_pop();
      exp_t e;
      bit   hit = 1'b0;
      for (int i = 0; i < 9; i++)
         drive(0, 16'($urandom), 16'($urandom), 1'b1);
      idle_in();
      for (int i = 0; i < 300 && !hit; i++) begin
         @(negedge clk);
         hit = !busy[0] && lvl0 == 4'd8;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL full_idle_reach got timeout want full+idle");
      end
      vld[0] = 1'b1;
      re0 = 16'h3C48;
      im0 = 16'hA5A5;
      e.w1 = model(re0);
      e.w2 = model(im0);
      sbq0.push_back(e);
      @(posedge clk);
      #1 vld[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (lvl0 !== 4'd8 || ovf[0] !== 1'b0) begin
         errors++;
         $display("FAIL push_pop got lvl=%0d ovf=%b want 8/0", lvl0, ovf[0]);
      end
      wait_drain(0, 1500);
      checks++;
      if (ovf[0] !== 1'b0) begin
         errors++;
         $display("FAIL push_pop_ovf got %b want 0", ovf[0]);
      end
   endtask

   task automatic test_clk_div1();
      starts1.delete();
      drive(1, 16'h4000, 16'hC000, 1'b1);
      drive(1, 16'h1238, 16'h7FFF, 1'b1);
      idle_in();
      wait_drain(1, 400);
      checks++;
      if (starts1.size() !== 2) begin
         errors++;
         $display("FAIL div1_count got %0d want 2", starts1.size());
      end else begin
         checks++;
         if (starts1[1] - starts1[0] !== 35) begin
            errors++;
            $display("FAIL div1_period got %0d want 35",
                     starts1[1] - starts1[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_saturation();
      test_overflow();
      test_reset_mid_frame();
      test_push_pop();
      test_clk_div1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dac_serial_bridge.md
Name: dac_serial_bridge

Overview:
- Sits directly downstream of the DUC: takes the DUC's 16-bit signed I/Q samples and their valid strobe.
- Rounds each sample to 12-bit offset-binary and buffers it in a small FIFO.
- Shifts each buffered sample to the dual-channel serial DAC: I on D1, Q on D2, with shared CLK_OUT and nSYNC.
- The DUC has no backpressure, so FIFO overrun is reported through a sticky flag rather than stalling upstream.

Parameters:
- CLK_DIV, 2: clk_in cycles per CLK_OUT half-period (>=1).
- FIFO_DEPTH, 8: sample-pair FIFO depth (power of 2, >=2).
- IN_W, 16: input sample width (signed two's complement).
- DAC_W, 12: DAC code width.

Ports:
- clk_in, in, 1: system clock; the only clock.
- rst, in, 1: reset, synchronous, active-high.
- in_valid, in, 1: input sample strobe (driven by the DUC valid output).
- in_re, in, IN_W: I sample, signed.
- in_im, in, IN_W: Q sample, signed.
- D1, out, 1: serial data, channel 1 (I).
- D2, out, 1: serial data, channel 2 (Q).
- CLK_OUT, out, 1: serial clock to the DAC.
- nSYNC, out, 1: active-low frame sync.
- frame_done, out, 1: one-cycle pulse when a frame completes.
- busy, out, 1: high whenever state is not IDLE.
- overflow, out, 1: sticky flag, set when an input sample is dropped.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset, synchronous, checked on the clk_in edge, overrides everything including a frame in progress:
  - state=IDLE, FIFO emptied, fifo_level=0, overflow=0.
  - nSYNC=1, CLK_OUT=1, D1=D2=0, frame_done=0, busy=0.
- Conversion, combinational on input, done before the FIFO write:
  - c = in[15:4] + in[3] (round half up).
  - If in[15:4]==0x7FF and in[3]==1, then c=0x7FF (saturate).
  - code = {~c[11], c[10:0]} (offset binary).
  - Frame word = {4'b0000, code}, 16 bits, MSB first.
- FIFO:
  - Push when in_valid=1 and (not full, or a pop happens in the same cycle).
  - in_valid=1 while full with no pop: sample dropped, overflow<=1; overflow stays set until rst.
  - A simultaneous push and pop leaves fifo_level unchanged.
  - Written data is visible to the FSM the next cycle.
- Divider: div_cnt counts 0..CLK_DIV-1; tick when div_cnt==CLK_DIV-1. div_cnt is cleared on entry to SHIFT and to GAP.
- FSM states IDLE, SHIFT, GAP:
  - IDLE: CLK_OUT=1, nSYNC=1. If the FIFO is non-empty, pop one pair, load the shift registers, drive nSYNC<=0, put the frame MSB on D1/D2, set bit_cnt=0, go to SHIFT.
  - SHIFT, tick with CLK_OUT=1: CLK_OUT<=0. This is the falling edge; the DAC samples D here.
  - SHIFT, tick with CLK_OUT=0: CLK_OUT<=1.
    - If bit_cnt==15: nSYNC<=1, D1=D2<=0, frame_done<=1 for one cycle, go to GAP.
    - Otherwise: bit_cnt++ and present the next bit on D1/D2.
  - D1/D2 change only on CLK_OUT rising edges or on frame load, so they are stable across every falling edge.
  - GAP: hold nSYNC=1, CLK_OUT=1 for 2*CLK_DIV cycles, then go to IDLE.
- Timing:
  - Latency: a pair pushed in cycle t pops in t+1 if the FSM is IDLE; nSYNC falls in t+2.
  - Throughput: steady-state frame period with the FIFO non-empty is 34*CLK_DIV+1 cycles (69 at the defaults). Input rate must not exceed this, otherwise overflow.
  - nSYNC is low for exactly 32*CLK_DIV cycles per frame, with 16 CLK_OUT falling edges inside it.
- Ordering and empty FIFO:
  - in_valid low: no FIFO effect.
  - Samples are emitted strictly in FIFO order.
  - FIFO empty in IDLE: the outputs idle indefinitely.

Test Plan:
- Single sample in_re=0x0000, in_im=0x1238 -> D1 frame 0x0800, D2 frame 0x0924. nSYNC low for 64 cycles with 16 CLK_OUT falling edges; frame_done pulses once; busy returns to 0.
- in_re=0x7FFF, in_im=0x8000 -> D1 0x0FFF (saturated), D2 0x0000. in_re=0x7FF7 -> D1 0x0FFF (no saturation needed).
- Overflow: 10 consecutive in_valid cycles from empty, CLK_DIV=2, FIFO_DEPTH=8:
  - 9 samples accepted (one popped at cycle 1), 10th dropped.
  - overflow=1 and fifo_level=8 after cycle 9.
  - All 9 frames emitted in order; back-to-back frames are 69 cycles apart.
- Reset mid-frame: assert rst for 1 cycle at bit 7 of the 2nd frame with 3 pairs queued -> next cycle nSYNC=1, CLK_OUT=1, fifo_level=0, overflow=0. No further frames until new input.
- Simultaneous push/pop: FIFO full and FSM popping in the same cycle as in_valid=1 -> sample accepted, fifo_level stays 8, overflow stays 0.
- CLK_DIV=1: single sample -> CLK_OUT period 2 cycles, nSYNC low for 32 cycles, data correct on every falling edge.
